// File: rtl/pc_return_stack_unit.sv
`default_nettype none
// ============================================================================
// pc_return_stack_unit : program counter sequencing with a call/ret stack.
// Rev 1.0
// ============================================================================
module pc_return_stack_unit #(
   parameter int ADDR_W   = 16,
   parameter int IMM_W    = 16,
   parameter int DEPTH    = 8,
   parameter int RESET_PC = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       write_pc,
   input  logic [2:0]                 branch,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       add_pc,
   input  logic                       brfl_control,
   input  logic                       flag_taken,
   input  logic [ADDR_W-1:0]          reg_target,
   input  logic [IMM_W-1:0]           imm,
   output logic [ADDR_W-1:0]          pc,
   output logic                       halted,
   output logic [$clog2(DEPTH+1)-1:0] stack_depth,
   output logic                       stack_full,
   output logic                       stack_empty,
   output logic                       stack_overflow,
   output logic                       stack_underflow
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] BR_JR   = 3'b001;
   localparam logic [2:0] BR_HALT = 3'b011;
   localparam logic [2:0] BR_JPC  = 3'b100;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [DW-1:0]     depth_q;
   logic [ADDR_W-1:0] imm_zext;
   logic [ADDR_W-1:0] imm_sext;

   // Immediate is truncated when wider than the pc, extended otherwise.
   generate
      if (IMM_W >= ADDR_W) begin : g_imm_trunc
         assign imm_zext = imm[ADDR_W-1:0];
         assign imm_sext = imm[ADDR_W-1:0];
      end else begin : g_imm_ext
         assign imm_zext = {{(ADDR_W-IMM_W){1'b0}}, imm};
         assign imm_sext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
      end
   endgenerate

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_rel;
   logic [DW-1:0]     depth_dec;
   logic [AW-1:0]     push_idx;
   logic [AW-1:0]     pop_idx;

   assign pc_inc    = pc + ADDR_W'(1);
   assign pc_rel    = pc_inc + imm_sext;
   assign depth_dec = depth_q - DW'(1);
   assign push_idx  = depth_q[AW-1:0];
   assign pop_idx   = depth_dec[AW-1:0];

   assign stack_depth = depth_q;
   assign stack_full  = (depth_q == DW'(DEPTH));
   assign stack_empty = (depth_q == '0);

   logic [ADDR_W-1:0] pc_next;
   logic [DW-1:0]     depth_next;
   logic              halted_next;
   logic              ovf_next;
   logic              unf_next;
   logic              push_en;

   always_comb begin
      pc_next     = pc;
      depth_next  = depth_q;
      halted_next = halted;
      ovf_next    = stack_overflow;
      unf_next    = stack_underflow;
      push_en     = 1'b0;
      if (write_pc && !halted) begin
         if (push && pop) begin
            pc_next = pc_inc;
         end else if (push) begin
            if (stack_full) begin
               ovf_next    = 1'b1;
               halted_next = 1'b1;
            end else begin
               push_en    = 1'b1;
               depth_next = depth_q + DW'(1);
               pc_next    = imm_zext;
            end
         end else if (pop) begin
            if (stack_empty) begin
               unf_next    = 1'b1;
               halted_next = 1'b1;
            end else begin
               depth_next = depth_dec;
               pc_next    = mem[pop_idx] + (add_pc ? ADDR_W'(1) : ADDR_W'(0));
            end
         end else if (branch == BR_HALT) begin
            halted_next = 1'b1;
         end else if (branch == BR_JR) begin
            pc_next = reg_target;
         end else if (branch == BR_JPC) begin
            pc_next = pc_rel;
         end else if (brfl_control) begin
            pc_next = flag_taken ? pc_rel : pc_inc;
         end else begin
            pc_next = pc_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc              <= ADDR_W'(RESET_PC);
         depth_q         <= '0;
         halted          <= 1'b0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         pc              <= pc_next;
         depth_q         <= depth_next;
         halted          <= halted_next;
         stack_overflow  <= ovf_next;
         stack_underflow <= unf_next;
      end
   end

   // Stack storage is not reset; depth alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push_en) mem[push_idx] <= pc;
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_return_stack_unit.sv
`default_nettype none
// tb_pc_return_stack_unit : directed self-checking bench for pc_return_stack_unit.
module tb_pc_return_stack_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write_pc = 1'b0;
   logic [2:0]  branch = 3'b000;
   logic        push = 1'b0, pop = 1'b0, add_pc = 1'b0;
   logic        brfl_control = 1'b0, flag_taken = 1'b0;
   logic [15:0] reg_target = '0, imm = '0;
   logic [15:0] pc;
   logic        halted, stack_full, stack_empty, stack_overflow, stack_underflow;
   logic [3:0]  stack_depth;

   int n_cmp = 0;
   int n_err = 0;

   pc_return_stack_unit #(.ADDR_W(16), .IMM_W(16), .DEPTH(8), .RESET_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .write_pc(write_pc), .branch(branch),
      .push(push), .pop(pop), .add_pc(add_pc), .brfl_control(brfl_control),
      .flag_taken(flag_taken), .reg_target(reg_target), .imm(imm),
      .pc(pc), .halted(halted), .stack_depth(stack_depth),
      .stack_full(stack_full), .stack_empty(stack_empty),
      .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One write_pc pulse spanning exactly one rising edge; returns at the following falling edge.
   task automatic commit(input logic [2:0] br, input logic ps, input logic pp, input logic ap,
                         input logic bf, input logic ft, input logic [15:0] rt, input logic [15:0] im);
      @(negedge clk);
      branch = br; push = ps; pop = pp; add_pc = ap;
      brfl_control = bf; flag_taken = ft; reg_target = rt; imm = im;
      write_pc = 1'b1;
      @(negedge clk);
      write_pc = 1'b0; push = 1'b0; pop = 1'b0; add_pc = 1'b0;
      brfl_control = 1'b0; flag_taken = 1'b0; branch = 3'b000;
   endtask

   task automatic seq();            commit(3'b000, 0, 0, 0, 0, 0, 16'h0, 16'h0);  endtask
   task automatic jr(input logic [15:0] t);   commit(3'b001, 0, 0, 0, 0, 0, t, 16'h0); endtask
   task automatic call(input logic [15:0] i); commit(3'b010, 1, 0, 0, 0, 0, 16'h0, i); endtask
   task automatic ret(input logic ap);        commit(3'b000, 0, 1, ap, 0, 0, 16'h0, 16'h0); endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset values
      #2;
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_depth", 32'(stack_depth), 32'h0);
      check("rst_empty", 32'(stack_empty), 32'h1);
      check("rst_full", 32'(stack_full), 32'h0);
      check("rst_ovf", 32'(stack_overflow), 32'h0);
      check("rst_unf", 32'(stack_underflow), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential increments and hold while write_pc is low
      for (int i = 1; i <= 5; i++) begin
         seq();
         check("seq_pc", 32'(pc), 32'(i));
         @(negedge clk);
         check("hold_pc", 32'(pc), 32'(i));
      end

      // call / ret with add_pc
      jr(16'h0010);
      check("jr_pc10", 32'(pc), 32'h10);
      call(16'h0040);
      check("call_pc", 32'(pc), 32'h40);
      check("call_depth", 32'(stack_depth), 32'h1);
      check("call_empty", 32'(stack_empty), 32'h0);
      ret(1'b1);
      check("ret_pc", 32'(pc), 32'h11);
      check("ret_depth", 32'(stack_depth), 32'h0);
      check("ret_empty", 32'(stack_empty), 32'h1);
      call(16'h8050);
      check("call_zext_pc", 32'(pc), 32'h8050);
      ret(1'b0);
      check("ret_noadd_pc", 32'(pc), 32'h11);

      // brfl taken / not taken, jr
      jr(16'h0008);
      commit(3'b000, 0, 0, 0, 1, 1, 16'h0, 16'h0004);
      check("brfl_taken", 32'(pc), 32'h0D);
      jr(16'h0008);
      commit(3'b000, 0, 0, 0, 1, 0, 16'h0, 16'h0004);
      check("brfl_not", 32'(pc), 32'h09);
      jr(16'h0123);
      check("jr_pc", 32'(pc), 32'h123);

      // jpc with negative offset, and pc wrap
      jr(16'h0020);
      commit(3'b100, 0, 0, 0, 0, 0, 16'h0, 16'hFFFE);
      check("jpc_neg", 32'(pc), 32'h1F);
      jr(16'hFFFF);
      seq();
      check("wrap_pc", 32'(pc), 32'h0);

      // push && pop together: no stack change, pc+1, no flags
      call(16'h0030);
      check("pp_pre_depth", 32'(stack_depth), 32'h1);
      commit(3'b010, 1, 1, 0, 0, 0, 16'h0, 16'h0077);
      check("pp_pc", 32'(pc), 32'h31);
      check("pp_depth", 32'(stack_depth), 32'h1);
      check("pp_flags", 32'({stack_overflow, stack_underflow, halted}), 32'h0);
      ret(1'b0);
      check("pp_ret_pc", 32'(pc), 32'h0);

      // halt is sticky and freezes pc
      commit(3'b011, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_pc", 32'(pc), 32'h0);
      jr(16'h0055);
      check("halt_hold", 32'(pc), 32'h0);

      // Fill the stack, LIFO read-back, overflow
      do_reset();
      check("rst2_halted", 32'(halted), 32'h0);
      for (int i = 0; i < 8; i++) call(16'(16'h0100 + i));
      check("fill_pc", 32'(pc), 32'h107);
      check("fill_full", 32'(stack_full), 32'h1);
      check("fill_depth", 32'(stack_depth), 32'h8);
      ret(1'b0);
      check("lifo_pc", 32'(pc), 32'h106);
      check("lifo_depth", 32'(stack_depth), 32'h7);
      call(16'h01FF);
      check("refill_full", 32'(stack_full), 32'h1);
      call(16'h0200);
      check("ovf_flag", 32'(stack_overflow), 32'h1);
      check("ovf_halted", 32'(halted), 32'h1);
      check("ovf_pc", 32'(pc), 32'h1FF);
      check("ovf_depth", 32'(stack_depth), 32'h8);
      seq();
      check("ovf_frozen", 32'(pc), 32'h1FF);
      do_reset();
      check("rst3_all", 32'({stack_overflow, stack_underflow, halted, stack_full, stack_empty}), 32'h1);
      check("rst3_pc", 32'(pc), 32'h0);
      check("rst3_depth", 32'(stack_depth), 32'h0);

      // Underflow
      ret(1'b1);
      check("unf_flag", 32'(stack_underflow), 32'h1);
      check("unf_halted", 32'(halted), 32'h1);
      check("unf_pc", 32'(pc), 32'h0);
      check("unf_depth", 32'(stack_depth), 32'h0);

      // Asynchronous reset between edges with depth 3
      do_reset();
      call(16'h0A00);
      call(16'h0B00);
      call(16'h0C00);
      check("async_pre_depth", 32'(stack_depth), 32'h3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_depth", 32'(stack_depth), 32'h0);
      check("async_pc", 32'(pc), 32'h0);
      check("async_empty", 32'(stack_empty), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      seq();
      check("post_async_pc", 32'(pc), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
